move_input_ctrl: RTL and testbench
==================================

// Module: move_input_ctrl
// PURPOSE
//  Player-side front end of connect4_top: owns the physical move interface (Switch_3..0 column select,
//  active-low, one-hot; BTN_EAST active-low commit) and turns each debounced press into one validated move
//  command for the board/win-check logic. It tracks per-column fill height, whose turn it is and the move
//  count on the 4x4 board. Board bit index = row*4+col, row 0 = bottom.
// PARAMETERS
//  DEBOUNCE_CYCLES  1   consecutive synchronized-low samples needed before BTN_EAST counts as pressed (>=1)
//  MAX_MOVES        16  cells on the board; count at which board_full asserts
// PORTS
//  clk          in   1  system clock, all logic rising-edge
//  reset        in   1  synchronous, active-high; clears all state
//  Switch_0     in   1  column 0 select, active-low, asynchronous to clk
//  Switch_1     in   1  column 1 select, active-low, asynchronous to clk
//  Switch_2     in   1  column 2 select, active-low, asynchronous to clk
//  Switch_3     in   1  column 3 select, active-low, asynchronous to clk
//  BTN_EAST     in   1  commit button, active-low, asynchronous, may bounce
//  game_over    in   1  level from win checker; when 1 every press is rejected
//  move_valid   out  1  1-cycle pulse: accepted move on move_col/row/player
//  move_col     out  2  column of accepted move (held until next accept)
//  move_row     out  2  landing row = column height before the move
//  move_player  out  1  0 = P1, 1 = P2; player who made the move
//  move_reject  out  1  1-cycle pulse: press refused, nothing changes
//  reject_code  out  2  01 switch pattern not one-hot-low, 10 column full, 11 game_over or board full
//  cur_player   out  1  player whose turn it is
//  moves_made   out  5  accepted-move count, 0..MAX_MOVES
//  board_full   out  1  moves_made == MAX_MOVES (tie if game_over never rose)
// BEHAVIOUR
//  - Reset: all outputs 0; heights[0..3]=0; FSM=IDLE; btn_db=1; debounce count=0; sync flops = 1.
//  - Inputs pass through 2-flop synchronizers. btn_db drops to 0 after DEBOUNCE_CYCLES consecutive
//    synced-low samples and returns to 1 after DEBOUNCE_CYCLES consecutive synced-high samples; the
//    counter restarts on any sample that disagrees.
//  - press = btn_db 1->0 transition (registered edge detect), 1 cycle wide.
//  - FSM: IDLE --press--> EVAL (latch synced switches) -> RESP -> WAIT_REL --btn_db==1--> IDLE.
//    A press seen outside IDLE is ignored; one press = exactly one move_valid or one move_reject.
//  - RESP priority: game_over|board_full -> code 11; else switches not exactly one 0 -> code 01;
//    else heights[col]==4 -> code 10; else accept.
//  - Accept: move_valid=1 in RESP cycle; move_row=heights[col]; move_player=cur_player;
//    heights[col]++, moves_made++, cur_player toggles, all visible the cycle after RESP.
//  - Reject: move_reject=1 with reject_code in RESP cycle; heights, count, player unchanged.
//    reject_code held until next response; move_col/row/player keep last accepted values.
//  - Latency: synced BTN_EAST low -> press after DEBOUNCE_CYCLES+1 cycles -> move_valid 2 cycles later.
//  - heights are 3-bit (0..4), never wrap; moves_made saturates at MAX_MOVES.
//  - move_valid and move_reject are never high together.
//  - game_over rising mid-EVAL is sampled in RESP (reject 11).
//  - Reset while in any state or with button held: full clear; a held button must release and be
//    pressed again (btn_db restarts at 1, so hold through reset produces a press only after debounce).
// TESTING
//  - Reset, switches 1110, press -> move_valid, col=0 row=0 player=0; cur_player=1, moves_made=1.
//  - Four presses with 0111 -> rows 0,1,2,3, players 0,1,0,1; fifth -> move_reject code 10, count stays 4.
//  - Switches 1100, then 1111, each pressed -> two rejects code 01; cur_player and moves_made unchanged.
//  - game_over=1, press 1101 -> reject code 11; drop game_over, press 1101 -> accepted, row 0.
//  - Fill all 16 cells -> board_full=1 at moves_made=16; 17th press -> reject 11.
//  - DEBOUNCE_CYCLES=4: low glitch of 3 cycles -> no response; button held 20 cycles -> exactly one move;
//    reset asserted during hold -> all outputs 0, no move on release.

Source files
------------

// File: rtl/move_input_ctrl.sv
// Player move front end: syncs and debounces the switches and button, then validates each press into one move or one reject.
// Latency: the press pulse comes DEBOUNCE_CYCLES+1 cycles after the synced button goes low; move_valid/move_reject follow 2 cycles later.
// No backpressure: one press gives exactly one response pulse; presses seen outside IDLE are dropped.
module move_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1,
    parameter int MAX_MOVES       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Switch_0,
    input  logic       Switch_1,
    input  logic       Switch_2,
    input  logic       Switch_3,
    input  logic       BTN_EAST,
    input  logic       game_over,
    output logic       move_valid,
    output logic [1:0] move_col,
    output logic [1:0] move_row,
    output logic       move_player,
    output logic       move_reject,
    output logic [1:0] reject_code,
    output logic       cur_player,
    output logic [4:0] moves_made,
    output logic       board_full
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, EVAL, RESP, WAIT_REL} state_t;

    state_t        state;
    logic [3:0]    sw_s1, sw_s2, sw_lat;
    logic          btn_s1, btn_s2;
    logic          btn_db, btn_db_d1, press;
    logic [CW-1:0] db_cnt;
    logic [2:0]    heights [4];

    logic [3:0]    sw_n;
    logic          one_hot;
    logic [1:0]    sel_col;

    // Two-flop synchronizers; idle level is 1 because every input is active-low
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_s1  <= 4'hF;
            sw_s2  <= 4'hF;
            btn_s1 <= 1'b1;
            btn_s2 <= 1'b1;
        end else begin
            sw_s1  <= {Switch_3, Switch_2, Switch_1, Switch_0};
            sw_s2  <= sw_s1;
            btn_s1 <= BTN_EAST;
            btn_s2 <= btn_s1;
        end
    end

    // Debounce: btn_db follows btn_s2 only after DEBOUNCE_CYCLES agreeing samples in a row, then a registered falling-edge detect
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_db    <= 1'b1;
            btn_db_d1 <= 1'b1;
            db_cnt    <= '0;
            press     <= 1'b0;
        end else begin
            if (btn_s2 != btn_db) begin
                if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    btn_db <= btn_s2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
            btn_db_d1 <= btn_db;
            press     <= btn_db_d1 & ~btn_db;
        end
    end

    // Decode the latched switch pattern: exactly one low switch selects the column
    always_comb begin
        sw_n    = ~sw_lat;
        one_hot = (sw_n != 4'b0000) && ((sw_n & (sw_n - 4'd1)) == 4'b0000);
        sel_col = 2'd0;
        case (sw_n)
            4'b0010: sel_col = 2'd1;
            4'b0100: sel_col = 2'd2;
            4'b1000: sel_col = 2'd3;
            default: sel_col = 2'd0;
        endcase
    end

    // Move FSM: decide in EVAL (outputs registered into RESP), commit board state at the end of RESP
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sw_lat      <= 4'hF;
            move_valid  <= 1'b0;
            move_col    <= 2'd0;
            move_row    <= 2'd0;
            move_player <= 1'b0;
            move_reject <= 1'b0;
            reject_code <= 2'd0;
            cur_player  <= 1'b0;
            moves_made  <= 5'd0;
            board_full  <= 1'b0;
            for (int i = 0; i < 4; i++) heights[i] <= 3'd0;
        end else begin
            move_valid  <= 1'b0;
            move_reject <= 1'b0;
            case (state)
                IDLE: begin
                    if (press) begin
                        sw_lat <= sw_s2;
                        state  <= EVAL;
                    end
                end
                EVAL: begin
                    state <= RESP;
                    if (game_over || board_full) begin
                        move_reject <= 1'b1;
                        reject_code <= 2'b11;
                    end else if (!one_hot) begin
                        move_reject <= 1'b1;
                        reject_code <= 2'b01;
                    end else if (heights[sel_col] == 3'd4) begin
                        move_reject <= 1'b1;
                        reject_code <= 2'b10;
                    end else begin
                        move_valid  <= 1'b1;
                        move_col    <= sel_col;
                        move_row    <= heights[sel_col][1:0];
                        move_player <= cur_player;
                        reject_code <= 2'b00;
                    end
                end
                RESP: begin
                    state <= WAIT_REL;
                    if (move_valid) begin
                        heights[move_col] <= heights[move_col] + 3'd1;
                        cur_player        <= ~cur_player;
                        if (moves_made != 5'(MAX_MOVES)) begin
                            moves_made <= moves_made + 5'd1;
                            board_full <= ((moves_made + 5'd1) == 5'(MAX_MOVES));
                        end
                    end
                end
                WAIT_REL: begin
                    if (btn_db) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_move_input_ctrl.sv
// Directed bench for move_input_ctrl: vector table for the main move/reject paths,
// hand sequences for board fill and the debounce/reset corner cases.
module tb_move_input_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, reset2, btn, btn2, go;
    logic [3:0] sw;

    logic       mv, mp, mj, cp, bf;
    logic [1:0] mc, mr, rc;
    logic [4:0] mm;
    logic       mv2, mp2, mj2, cp2, bf2;
    logic [1:0] mc2, mr2, rc2;
    logic [4:0] mm2;

    move_input_ctrl u_dut (
        .clk(clk), .reset(reset),
        .Switch_0(sw[0]), .Switch_1(sw[1]), .Switch_2(sw[2]), .Switch_3(sw[3]),
        .BTN_EAST(btn), .game_over(go),
        .move_valid(mv), .move_col(mc), .move_row(mr), .move_player(mp),
        .move_reject(mj), .reject_code(rc), .cur_player(cp),
        .moves_made(mm), .board_full(bf)
    );

    move_input_ctrl #(.DEBOUNCE_CYCLES(4), .MAX_MOVES(16)) u_db4 (
        .clk(clk), .reset(reset2),
        .Switch_0(sw[0]), .Switch_1(sw[1]), .Switch_2(sw[2]), .Switch_3(sw[3]),
        .BTN_EAST(btn2), .game_over(go),
        .move_valid(mv2), .move_col(mc2), .move_row(mr2), .move_player(mp2),
        .move_reject(mj2), .reject_code(rc2), .cur_player(cp2),
        .moves_made(mm2), .board_full(bf2)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Response pulse counters, sampled mid-cycle
    int nv = 0, nr = 0, nboth = 0, nv2 = 0, nr2 = 0;
    always @(negedge clk) begin
        if (mv) nv++;
        if (mj) nr++;
        if (mv && mj) nboth++;
        if (mv2) nv2++;
        if (mj2) nr2++;
    end

    typedef struct {
        logic [3:0] sw;
        logic       go;
        logic       valid;
        logic [1:0] code;
        logic [1:0] col;
        logic [1:0] row;
        logic       pl;
        int         moves;
        logic       cur;
    } vec_t;

    vec_t tv [10];

    logic       r_v, r_j, r_pl;
    logic [1:0] r_col, r_row, r_code;
    int         r_lat, r_npulse;

    // Press the button on u_dut with a given switch pattern and capture the response
    task automatic do_press(input logic [3:0] p);
        int s;
        sw = p;
        repeat (3) @(negedge clk);
        s = nv + nr;
        btn = 1'b0;
        r_lat = 0;
        while (!(mv || mj) && r_lat < 40) begin
            @(negedge clk);
            r_lat++;
        end
        if (r_lat >= 40) chk("response_timeout", r_lat, 0);
        r_v = mv; r_j = mj; r_col = mc; r_row = mr; r_pl = mp; r_code = rc;
        repeat (4) @(negedge clk);
        btn = 1'b1;
        repeat (8) @(negedge clk);
        r_npulse = nv + nr - s;
    endtask

    int h [4];
    int e_moves;
    logic e_cur;
    int cols [10];

    initial begin
        int s, lat;
        reset = 1'b1; reset2 = 1'b1; btn = 1'b1; btn2 = 1'b1; go = 1'b0; sw = 4'hF;

        tv[0] = '{4'b1110, 1'b0, 1'b1, 2'b00, 2'd0, 2'd0, 1'b0, 1, 1'b1};
        tv[1] = '{4'b0111, 1'b0, 1'b1, 2'b00, 2'd3, 2'd0, 1'b1, 2, 1'b0};
        tv[2] = '{4'b0111, 1'b0, 1'b1, 2'b00, 2'd3, 2'd1, 1'b0, 3, 1'b1};
        tv[3] = '{4'b0111, 1'b0, 1'b1, 2'b00, 2'd3, 2'd2, 1'b1, 4, 1'b0};
        tv[4] = '{4'b0111, 1'b0, 1'b1, 2'b00, 2'd3, 2'd3, 1'b0, 5, 1'b1};
        tv[5] = '{4'b0111, 1'b0, 1'b0, 2'b10, 2'd3, 2'd3, 1'b0, 5, 1'b1};
        tv[6] = '{4'b1100, 1'b0, 1'b0, 2'b01, 2'd3, 2'd3, 1'b0, 5, 1'b1};
        tv[7] = '{4'b1111, 1'b0, 1'b0, 2'b01, 2'd3, 2'd3, 1'b0, 5, 1'b1};
        tv[8] = '{4'b1101, 1'b1, 1'b0, 2'b11, 2'd3, 2'd3, 1'b0, 5, 1'b1};
        tv[9] = '{4'b1101, 1'b0, 1'b1, 2'b00, 2'd1, 2'd0, 1'b1, 6, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({mv, mc, mr, mp, mj, rc, cp, mm, bf}), 0);
        reset = 1'b0;
        reset2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_outputs", int'({mv, mj, cp, mm, bf}), 0);

        for (int i = 0; i < 10; i++) begin
            go = tv[i].go;
            do_press(tv[i].sw);
            go = 1'b0;
            if (i == 0) chk("latency_db1", r_lat, 6);
            chk($sformatf("v%0d_valid", i), r_v, tv[i].valid);
            chk($sformatf("v%0d_reject", i), r_j, !tv[i].valid);
            if (!tv[i].valid) chk($sformatf("v%0d_code", i), r_code, tv[i].code);
            chk($sformatf("v%0d_col", i), r_col, tv[i].col);
            chk($sformatf("v%0d_row", i), r_row, tv[i].row);
            chk($sformatf("v%0d_player", i), r_pl, tv[i].pl);
            chk($sformatf("v%0d_moves", i), mm, tv[i].moves);
            chk($sformatf("v%0d_cur", i), cp, tv[i].cur);
            chk($sformatf("v%0d_pulses", i), r_npulse, 1);
        end

        // Fill the remaining 10 cells
        h[0] = 1; h[1] = 1; h[2] = 0; h[3] = 4;
        e_moves = 6; e_cur = 1'b0;
        cols = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 2};
        for (int k = 0; k < 10; k++) begin
            logic [3:0] one;
            one = 4'b0001 << cols[k];
            do_press(~one);
            chk($sformatf("fill%0d_valid", k), r_v, 1);
            chk($sformatf("fill%0d_col", k), r_col, cols[k]);
            chk($sformatf("fill%0d_row", k), r_row, h[cols[k]]);
            chk($sformatf("fill%0d_player", k), r_pl, e_cur);
            h[cols[k]]++;
            e_moves++;
            e_cur = ~e_cur;
            chk($sformatf("fill%0d_moves", k), mm, e_moves);
            chk($sformatf("fill%0d_full", k), bf, (e_moves == 16) ? 1 : 0);
        end
        do_press(4'b1110);
        chk("full_reject", r_j, 1);
        chk("full_valid", r_v, 0);
        chk("full_code", r_code, 3);
        chk("full_moves", mm, 16);
        chk("never_both", nboth, 0);

        // Debounce width 4: a 3-cycle glitch must not register
        sw = 4'b1110;
        s = nv2 + nr2;
        btn2 = 1'b0;
        repeat (3) @(negedge clk);
        btn2 = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_no_resp", nv2 + nr2 - s, 0);

        // Held 20 cycles: exactly one move
        s = nv2 + nr2;
        btn2 = 1'b0;
        lat = 0;
        while (!mv2 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency_db4", lat, 9);
        repeat (20 - lat) @(negedge clk);
        btn2 = 1'b1;
        repeat (20) @(negedge clk);
        chk("hold_one_resp", nv2 + nr2 - s, 1);
        chk("hold_moves", mm2, 1);
        chk("hold_cur", cp2, 1);

        // Reset while held: full clear, no move after release
        btn2 = 1'b0;
        repeat (4) @(negedge clk);
        reset2 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_hold_outputs", int'({mv2, mc2, mr2, mp2, mj2, rc2, cp2, mm2, bf2}), 0);
        reset2 = 1'b0;
        s = nv2 + nr2;
        @(negedge clk);
        btn2 = 1'b1;
        repeat (30) @(negedge clk);
        chk("rst_hold_no_resp", nv2 + nr2 - s, 0);
        chk("rst_hold_moves", mm2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
